ofmap_axis_streamer: RTL and testbench

- Reads wide result lines from an on-chip buffer (BRAM, synchronous read, 1-cycle latency) and serializes each line into AXI-Stream beats towards the write-back DMA (S2MM).
- Transmit-side counterpart of the weight-load path: it performs the parallel-to-serial conversion and drives the AXI-Stream master.
- Sits between the output feature-map buffer and the DMA and is triggered by the layer controller.

---
 rtl/ofmap_axis_streamer_if.sv | 13 +
 rtl/ofmap_axis_streamer.sv | 143 ++++++++++++++
 tb/tb_ofmap_axis_streamer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ofmap_axis_streamer_if.sv
// AXI-Stream bundle used between the ofmap streamer and the S2MM write-back DMA.
// The master drives valid/data/last; the slave drives ready.
interface ofmap_axis_streamer_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/ofmap_axis_streamer.sv
// Reads result lines from the ofmap buffer and serializes each line into AXI-Stream beats.
// The lowest slice of a line goes out first; tlast marks the final beat of the frame.
module ofmap_axis_streamer #(
    parameter  int AXIS_DATA_WIDTH = 64,
    parameter  int LINE_WIDTH      = 1152,
    parameter  int BRAM_DEPTH      = 512,
    localparam int BEATS_PER_LINE  = LINE_WIDTH / AXIS_DATA_WIDTH,
    localparam int AW              = $clog2(BRAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [AW-1:0]         i_base_addr,
    input  logic [AW:0]           i_num_lines,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_rd_en,
    output logic [AW-1:0]         o_rd_addr,
    input  logic [LINE_WIDTH-1:0] i_rd_data,
    ofmap_axis_streamer_if.master m_axis
);
    localparam int BCW = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        LOAD = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                 state_reg;
    logic [LINE_WIDTH-1:0]  line_reg;
    logic [BCW-1:0]         beat_cnt_reg;
    logic [AW:0]            lines_left_reg;
    logic [AW-1:0]          rd_ptr_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   rd_en_reg;
    logic [AW-1:0]          rd_addr_reg;
    logic                   tvalid_reg;
    logic                   tlast_reg;

    logic [AXIS_DATA_WIDTH-1:0] beat_slice [BEATS_PER_LINE];
    logic                       last_beat;
    logic [AW-1:0]              ptr_next;
    logic [BCW-1:0]             beat_cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < BEATS_PER_LINE; gi++) begin : g_slice
            assign beat_slice[gi] = line_reg[gi*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        end
    endgenerate

    assign last_beat     = (beat_cnt_reg == BCW'(BEATS_PER_LINE - 1));
    assign beat_cnt_next = beat_cnt_reg + 1'b1;
    // Line pointer wraps explicitly so non power-of-two depths still work.
    assign ptr_next      = (rd_ptr_reg == AW'(BRAM_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            line_reg       <= '0;
            beat_cnt_reg   <= '0;
            lines_left_reg <= '0;
            rd_ptr_reg     <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            rd_en_reg      <= 1'b0;
            rd_addr_reg    <= '0;
            tvalid_reg     <= 1'b0;
            tlast_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (i_start) begin
                        busy_reg       <= 1'b1;
                        rd_ptr_reg     <= i_base_addr;
                        lines_left_reg <= i_num_lines;
                        if (i_num_lines == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg   <= READ;
                            rd_en_reg   <= 1'b1;
                            rd_addr_reg <= i_base_addr;
                        end
                    end
                end
                READ: begin
                    rd_en_reg <= 1'b0;
                    state_reg <= LOAD;
                end
                LOAD: begin
                    line_reg     <= i_rd_data;
                    beat_cnt_reg <= '0;
                    tvalid_reg   <= 1'b1;
                    tlast_reg    <= (BEATS_PER_LINE == 1) && (lines_left_reg == (AW+1)'(1));
                    state_reg    <= SEND;
                end
                SEND: begin
                    if (m_axis.tready) begin
                        if (last_beat) begin
                            tvalid_reg     <= 1'b0;
                            tlast_reg      <= 1'b0;
                            beat_cnt_reg   <= '0;
                            lines_left_reg <= lines_left_reg - 1'b1;
                            rd_ptr_reg     <= ptr_next;
                            if (lines_left_reg > (AW+1)'(1)) begin
                                state_reg   <= READ;
                                rd_en_reg   <= 1'b1;
                                rd_addr_reg <= ptr_next;
                            end else begin
                                state_reg <= DONE;
                                done_reg  <= 1'b1;
                            end
                        end else begin
                            beat_cnt_reg <= beat_cnt_next;
                            tlast_reg    <= (beat_cnt_next == BCW'(BEATS_PER_LINE - 1)) &&
                                            (lines_left_reg == (AW+1)'(1));
                        end
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_busy        = busy_reg;
    assign o_done        = done_reg;
    assign o_rd_en       = rd_en_reg;
    assign o_rd_addr     = rd_addr_reg;
    assign m_axis.tvalid = tvalid_reg;
    assign m_axis.tlast  = tlast_reg;
    assign m_axis.tdata  = beat_slice[beat_cnt_reg];
endmodule

// File: tb/tb_ofmap_axis_streamer.sv
// Scoreboard bench for ofmap_axis_streamer: a BRAM model feeds the DUT and expected
// beats/reads are derived from the buffer contents, checked by an independent monitor.
module tb_ofmap_axis_streamer;
    localparam int DW    = 64;
    localparam int LW    = 1152;
    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int BEATS = LW / DW;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic          i_start;
    logic [AW-1:0] i_base_addr;
    logic [AW:0]   i_num_lines;
    logic          o_busy;
    logic          o_done;
    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic [LW-1:0] i_rd_data;

    ofmap_axis_streamer_if #(.DATA_WIDTH(DW)) axis ();

    ofmap_axis_streamer #(
        .AXIS_DATA_WIDTH(DW),
        .LINE_WIDTH     (LW),
        .BRAM_DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_base_addr(i_base_addr),
        .i_num_lines(i_num_lines),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_rd_en    (o_rd_en),
        .o_rd_addr  (o_rd_addr),
        .i_rd_data  (i_rd_data),
        .m_axis     (axis.master)
    );

    logic [LW-1:0] mem [DEPTH];
    beat_t         sb[$];
    int            exp_rd[$];
    int            vectors = 0;
    int            miscompares = 0;
    int            hs_cnt = 0;
    bit            bp_mode = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (o_rd_en) i_rd_data <= mem[o_rd_addr];
    end

    always @(posedge clk) begin
        #1;
        axis.tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops expected beats/reads and checks AXIS stability under stalls.
    initial begin
        bit            prev_stall;
        logic [DW-1:0] prev_d;
        logic          prev_l;
        prev_stall = 0;
        prev_d     = '0;
        prev_l     = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_tvalid", 64'(axis.tvalid), 64'd1);
                    chk("stall_tdata", axis.tdata, prev_d);
                    chk("stall_tlast", 64'(axis.tlast), 64'(prev_l));
                end
                if (axis.tvalid && axis.tready) begin
                    hs_cnt++;
                    if (sb.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
                    else begin
                        beat_t b;
                        b = sb.pop_front();
                        chk("tdata", axis.tdata, b.d);
                        chk("tlast", 64'(axis.tlast), 64'(b.l));
                    end
                end
                if (o_rd_en) begin
                    if (exp_rd.size() == 0) chk("unexpected_read", 64'd1, 64'd0);
                    else chk("rd_addr", 64'(o_rd_addr), 64'(exp_rd.pop_front()));
                end
                prev_stall = axis.tvalid && !axis.tready;
                prev_d     = axis.tdata;
                prev_l     = axis.tlast;
            end
        end
    end

    task automatic push_exp(input int base, input int n);
        for (int l = 0; l < n; l++) begin
            int a;
            a = (base + l) % DEPTH;
            exp_rd.push_back(a);
            for (int k = 0; k < BEATS; k++) begin
                beat_t b;
                b.d = mem[a][k*DW +: DW];
                b.l = (l == n - 1) && (k == BEATS - 1);
                sb.push_back(b);
            end
        end
    endtask

    task automatic pulse_start(input int base, input int n);
        @(posedge clk);
        #1;
        i_start     = 1'b1;
        i_base_addr = AW'(base);
        i_num_lines = (AW+1)'(n);
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic run_frame(input int base, input int n, input bit timed, input bit inject);
        int cyc;
        bit got;
        push_exp(base, n);
        pulse_start(base, n);
        cyc = 0;
        got = 0;
        while (!got && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (inject && cyc == 4) begin
                i_start     = 1'b1;
                i_base_addr = AW'((base + 100) % DEPTH);
                i_num_lines = (AW+1)'(n + 3);
            end
            if (inject && cyc == 5) i_start = 1'b0;
            chk("busy", 64'(o_busy), 64'd1);
            if (o_done) got = 1;
        end
        chk("done_seen", 64'(got), 64'd1);
        if (timed) chk("frame_cycles", 64'(cyc), 64'(n * (BEATS + 2) + 1));
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("rd_empty", 64'(exp_rd.size()), 64'd0);
        @(negedge clk);
        chk("busy_after", 64'(o_busy), 64'd0);
        chk("done_after", 64'(o_done), 64'd0);
        $display("frame base=%0d lines=%0d bp=%0d inject=%0d cycles=%0d", base, n, bp_mode, inject, cyc);
    endtask

    task automatic fill_random();
        for (int a = 0; a < DEPTH; a++)
            for (int j = 0; j < LW / 32; j++)
                mem[a][j*32 +: 32] = $urandom;
    endtask

    initial begin
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_base_addr = '0;
        i_num_lines = '0;
        i_rd_data   = '0;
        axis.tready = 1'b1;
        fill_random();
        for (int k = 0; k < BEATS; k++) mem[0][k*DW +: DW] = 64'(k);

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_rd_en", 64'(o_rd_en), 64'd0);
        chk("rst_tvalid", 64'(axis.tvalid), 64'd0);
        chk("rst_tlast", 64'(axis.tlast), 64'd0);
        chk("rst_tdata", axis.tdata, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        bp_mode = 0;
        run_frame(0, 1, 1, 0);
        run_frame(510, 3, 1, 0);
        run_frame(7, 0, 1, 0);

        bp_mode = 1;
        run_frame(200, 2, 0, 0);
        bp_mode = 0;
        run_frame(200, 2, 1, 0);

        run_frame(33, 2, 1, 1);
        run_frame(300, 1, 1, 0);

        // Reset in the middle of line 0, then a clean frame afterwards.
        begin
            int t0;
            int guard;
            t0 = hs_cnt;
            guard = 0;
            push_exp(40, 2);
            pulse_start(40, 2);
            while (hs_cnt < t0 + 7 && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            chk("rst_wait", 64'(guard < 1000), 64'd1);
            #2;
            rst_n = 1'b0;
            #1;
            chk("mid_rst_tvalid", 64'(axis.tvalid), 64'd0);
            chk("mid_rst_tlast", 64'(axis.tlast), 64'd0);
            chk("mid_rst_busy", 64'(o_busy), 64'd0);
            chk("mid_rst_rd_en", 64'(o_rd_en), 64'd0);
            sb.delete();
            exp_rd.delete();
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("mid_rst_done", 64'(o_done), 64'd0);
            end
            rst_n = 1'b1;
            repeat (2) @(negedge clk);
            chk("post_rst_done", 64'(o_done), 64'd0);
            run_frame(40, 2, 1, 0);
        end

        for (int r = 0; r < 4; r++) begin
            bp_mode = 1'($urandom_range(0, 1));
            run_frame(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 4)), !bp_mode, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
